// File: rtl/uart_alu_pkg.sv
// Shared definitions for the ALU-to-UART result path: transmitter byte width,
// result-sender FSM encoding and an elaboration-time log2 helper.
package uart_alu_pkg;

    localparam int NB_BYTE = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

    // Smallest n with 2**n >= value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result = result + 1;
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; a push into a full FIFO is
// accepted when a pop in the same cycle frees the head slot.
module sync_fifo
    import uart_alu_pkg::*;
#(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 4,
    localparam int AW    = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1,
    localparam int CW    = clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_ok;
    logic             pop_ok;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign push_ok = i_push && (!o_full || i_pop);
    assign pop_ok  = i_pop && !o_empty;

    always_comb begin
        // NOTE: default assigned first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // NOTE: storage has no reset; pointers and count alone say which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_data;
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/uart_result_sender.sv
// Queues signed ALU results and streams each one MSB byte first to an 8-bit
// UART transmitter through its start/busy handshake.
module uart_result_sender
    import uart_alu_pkg::*;
#(
    parameter int  NB_RESULT   = 16,
    parameter int  FIFO_DEPTH  = 4,
    parameter int  ACK_TIMEOUT = 8,
    localparam int NB_COUNT    = clog2(FIFO_DEPTH) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NB_RESULT-1:0] i_result,
    input  logic                 i_result_valid,
    input  logic                 i_tx_busy,
    output logic                 o_tx_start,
    output logic [NB_BYTE-1:0]   o_tx_data,
    output logic [NB_COUNT-1:0]  o_count,
    output logic                 o_full,
    output logic                 o_sending,
    output logic                 o_word_done,
    output logic                 o_overflow,
    output logic                 o_ack_timeout
);

    localparam int NB_WORD_BYTES = NB_RESULT / NB_BYTE;
    localparam int NB_IDX        = (clog2(NB_WORD_BYTES) > 0) ? clog2(NB_WORD_BYTES) : 1;
    localparam int NB_TIMER      = (clog2(ACK_TIMEOUT) > 0) ? clog2(ACK_TIMEOUT) : 1;
    localparam logic [NB_IDX-1:0]   LAST_IDX  = NB_IDX'(NB_WORD_BYTES - 1);
    localparam logic [NB_TIMER-1:0] LAST_TICK = NB_TIMER'(ACK_TIMEOUT - 1);

    tx_state_e            state_q,    state_d;
    logic [NB_RESULT-1:0] word_q,     word_d;
    logic [NB_IDX-1:0]    idx_q,      idx_d;
    logic [NB_IDX-1:0]    idx_next;
    logic [NB_TIMER-1:0]  timer_q,    timer_d;
    logic [NB_BYTE-1:0]   data_q,     data_d;
    logic                 done_q,     done_d;
    logic                 overflow_q, overflow_d;
    logic                 timeout_q,  timeout_d;

    logic [NB_RESULT-1:0] fifo_head;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 push_dropped;

    // Byte idx of a word, counting from the most significant byte.
    function automatic logic [NB_BYTE-1:0] word_byte(input logic [NB_RESULT-1:0] word,
                                                     input logic [NB_IDX-1:0]    idx);
        return NB_BYTE'(word >> (NB_BYTE * (NB_WORD_BYTES - 1 - int'(idx))));
    endfunction

    assign fifo_pop     = (state_q == ST_IDLE) && !fifo_empty;
    assign push_dropped = i_result_valid && o_full && !fifo_pop;
    assign idx_next     = idx_q + 1'b1;

    sync_fifo #(
        .WIDTH (NB_RESULT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_result_valid),
        .i_data  (i_result),
        .i_pop   (fifo_pop),
        .o_data  (fifo_head),
        .o_count (o_count),
        .o_full  (o_full),
        .o_empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        data_d     = data_q;
        done_d     = 1'b0;
        overflow_d = overflow_q | push_dropped;
        timeout_d  = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    word_d  = fifo_head;
                    idx_d   = '0;
                    data_d  = fifo_head[NB_RESULT-1 -: NB_BYTE];
                    state_d = ST_START;
                end
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (i_tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == LAST_TICK) begin
                    // Transmitter never answered: drop the rest of this word.
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_next;
                        data_d  = word_byte(word_q, idx_next);
                        state_d = ST_START;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            data_q     <= data_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_tx_start    = (state_q == ST_START);
    assign o_tx_data     = data_q;
    assign o_sending     = (state_q != ST_IDLE);
    assign o_word_done   = done_q;
    assign o_overflow    = overflow_q;
    assign o_ack_timeout = timeout_q;

endmodule

// File: tb/tb_uart_result_sender.sv
// Directed bench for uart_result_sender: a sequential reference model predicts
// every output each cycle; literal checks on the byte log pin the model.
module tb_uart_result_sender;

    localparam int NB_RESULT     = 16;
    localparam int FIFO_DEPTH    = 4;
    localparam int ACK_TIMEOUT   = 8;
    localparam int NB_WORD_BYTES = NB_RESULT / 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NB_RESULT-1:0] result = '0;
    logic                 valid = 1'b0;
    logic                 busy;
    logic                 o_tx_start;
    logic [7:0]           o_tx_data;
    logic [2:0]           o_count;
    logic                 o_full;
    logic                 o_sending;
    logic                 o_word_done;
    logic                 o_overflow;
    logic                 o_ack_timeout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit checking = 1'b0;

    uart_result_sender #(
        .NB_RESULT   (NB_RESULT),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_result       (result),
        .i_result_valid (valid),
        .i_tx_busy      (busy),
        .o_tx_start     (o_tx_start),
        .o_tx_data      (o_tx_data),
        .o_count        (o_count),
        .o_full         (o_full),
        .o_sending      (o_sending),
        .o_word_done    (o_word_done),
        .o_overflow     (o_overflow),
        .o_ack_timeout  (o_ack_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transmitter model: busy rises the cycle after a start and stays high 10 cycles.
    bit tx_silent = 1'b0;
    bit hold_busy = 1'b0;
    bit tx_busy   = 1'b0;
    bit start_seen = 1'b0;
    int tx_rem    = 0;
    assign busy = hold_busy | tx_busy;

    always @(negedge clk) start_seen = (o_tx_start === 1'b1);
    always @(posedge clk) begin
        #1;
        if (start_seen && !tx_silent) begin
            tx_busy = 1'b1;
            tx_rem  = 9;
        end else if (tx_rem > 0) begin
            tx_rem--;
        end else begin
            tx_busy = 1'b0;
        end
    end

    // Reference model: queue of results plus a sequential sender program.
    logic [NB_RESULT-1:0] mq[$];
    bit         m_ovf = 1'b0;
    bit         m_to = 1'b0;
    bit         exp_start = 1'b0;
    bit         exp_done = 1'b0;
    bit         exp_sending = 1'b0;
    logic [7:0] exp_data = '0;

    task automatic m_edge(input bit do_pop, output logic [NB_RESULT-1:0] w,
                          output bit rst, output bit bsy);
        @(posedge clk);
        rst = reset;
        bsy = busy;
        w   = '0;
        if (reset) begin
            mq.delete();
            m_ovf       = 1'b0;
            m_to        = 1'b0;
            exp_start   = 1'b0;
            exp_done    = 1'b0;
            exp_sending = 1'b0;
            exp_data    = '0;
        end else begin
            if (do_pop) w = mq.pop_front();
            if (valid) begin
                if (mq.size() < FIFO_DEPTH) mq.push_back(result);
                else m_ovf = 1'b1;
            end
        end
    endtask

    initial begin : model
        bit take;
        bit rst;
        bit bsy;
        bit acked;
        logic [NB_RESULT-1:0] w;
        logic [NB_RESULT-1:0] w_unused;
        forever begin
            exp_start   = 1'b0;
            exp_sending = 1'b0;
            take = (mq.size() > 0);
            m_edge(take, w, rst, bsy);
            exp_done = 1'b0;
            if (rst || !take) continue;
            for (int b = 0; b < NB_WORD_BYTES; b++) begin
                exp_sending = 1'b1;
                exp_start   = 1'b1;
                exp_data    = w[NB_RESULT-1-8*b -: 8];
                m_edge(1'b0, w_unused, rst, bsy);
                exp_start = 1'b0;
                if (rst) break;
                acked = 1'b0;
                for (int t = 0; t < ACK_TIMEOUT; t++) begin
                    m_edge(1'b0, w_unused, rst, bsy);
                    if (rst || bsy) begin
                        acked = bsy && !rst;
                        break;
                    end
                end
                if (rst) break;
                if (!acked) begin
                    m_to = 1'b1;
                    break;
                end
                forever begin
                    m_edge(1'b0, w_unused, rst, bsy);
                    if (rst || !bsy) break;
                end
                if (rst) break;
                if (b == NB_WORD_BYTES - 1) exp_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("tx_start",    {31'd0, o_tx_start},    {31'd0, exp_start});
            check("tx_data",     {24'd0, o_tx_data},     {24'd0, exp_data});
            check("count",       {29'd0, o_count},       mq.size());
            check("full",        {31'd0, o_full},        {31'd0, mq.size() == FIFO_DEPTH});
            check("sending",     {31'd0, o_sending},     {31'd0, exp_sending});
            check("word_done",   {31'd0, o_word_done},   {31'd0, exp_done});
            check("overflow",    {31'd0, o_overflow},    {31'd0, m_ovf});
            check("ack_timeout", {31'd0, o_ack_timeout}, {31'd0, m_to});
        end
    end

    // Byte log for the literal expectations.
    logic [7:0] log_b[$];
    int         log_c[$];
    int         done_cnt = 0;
    int         max_cnt = 0;

    always @(negedge clk) begin
        if (checking) begin
            if (o_tx_start === 1'b1) begin
                log_b.push_back(o_tx_data);
                log_c.push_back(cyc);
            end
            if (o_word_done === 1'b1) done_cnt++;
            if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
        end
    end

    function automatic logic [7:0] lb(input int i);
        if (i < log_b.size()) return log_b[i];
        return 8'h00;
    endfunction

    function automatic int lc(input int i);
        if (i < log_c.size()) return log_c[i];
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [NB_RESULT-1:0] v);
        valid  = 1'b1;
        result = v;
        tick(1);
        valid  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(o_sending === 1'b0 && o_count === 3'd0 && busy === 1'b0) && n < budget) begin
            tick(1);
            n++;
        end
        check({name, " reaches idle"}, {31'd0, n < budget}, 32'd1);
        tick(2);
    endtask

    initial begin : stimulus
        int base;
        int d0;
        int pcyc;
        logic [7:0] exp_bytes [10];

        tick(1);
        checking = 1'b1;
        tick(2);
        check("reset tx_start", {31'd0, o_tx_start}, 32'd0);
        check("reset tx_data",  {24'd0, o_tx_data},  32'd0);
        check("reset count",    {29'd0, o_count},    32'd0);
        check("reset sending",  {31'd0, o_sending},  32'd0);
        check("reset sticky",   {30'd0, o_overflow, o_ack_timeout}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Single word
        base = log_b.size(); d0 = done_cnt; pcyc = cyc;
        push(16'hBEEF);
        wait_idle("single", 100);
        check("single nbytes",  log_b.size() - base, 32'd2);
        check("single byte0",   {24'd0, lb(base)},     32'hBE);
        check("single byte1",   {24'd0, lb(base + 1)}, 32'hEF);
        check("single latency", lc(base) - pcyc, 32'd2);
        check("single gap",     lc(base + 1) - lc(base), 32'd12);
        check("single done",    done_cnt - d0, 32'd1);
        check("single count",   {29'd0, o_count}, 32'd0);

        // Negative result
        base = log_b.size(); d0 = done_cnt;
        push(16'hFFF9);
        wait_idle("negative", 100);
        check("negative nbytes", log_b.size() - base, 32'd2);
        check("negative byte0",  {24'd0, lb(base)},     32'hFF);
        check("negative byte1",  {24'd0, lb(base + 1)}, 32'hF9);
        check("negative done",   done_cnt - d0, 32'd1);

        // Back-to-back words
        base = log_b.size(); d0 = done_cnt; max_cnt = 0;
        push(16'h0102);
        push(16'h0304);
        push(16'h0506);
        wait_idle("b2b", 200);
        check("b2b nbytes", log_b.size() - base, 32'd6);
        for (int i = 0; i < 6; i++) check("b2b byte", {24'd0, lb(base + i)}, i + 1);
        check("b2b peak count", {31'd0, max_cnt == 2 || max_cnt == 3}, 32'd1);
        check("b2b done", done_cnt - d0, 32'd3);

        // Overflow with the transmitter held busy
        base = log_b.size(); d0 = done_cnt;
        hold_busy = 1'b1;
        push(16'h1122);
        push(16'h3344);
        push(16'h5566);
        push(16'h7788);
        push(16'h99AA);
        push(16'hBBCC);
        check("overflow count",  {29'd0, o_count},    32'd4);
        check("overflow full",   {31'd0, o_full},     32'd1);
        check("overflow flag",   {31'd0, o_overflow}, 32'd1);
        tick(20);
        hold_busy = 1'b0;
        wait_idle("overflow", 400);
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
        check("overflow nbytes", log_b.size() - base, 32'd10);
        for (int i = 0; i < 10; i++) check("overflow byte", {24'd0, lb(base + i)}, {24'd0, exp_bytes[i]});
        check("overflow done",   done_cnt - d0, 32'd5);
        check("overflow sticky", {31'd0, o_overflow}, 32'd1);

        // Ack timeout: transmitter never answers
        base = log_b.size(); d0 = done_cnt;
        tx_silent = 1'b1;
        push(16'hCAFE);
        push(16'hD00D);
        wait_idle("timeout", 200);
        check("timeout nstarts", log_b.size() - base, 32'd2);
        check("timeout byte0",   {24'd0, lb(base)},     32'hCA);
        check("timeout byte1",   {24'd0, lb(base + 1)}, 32'hD0);
        check("timeout gap",     lc(base + 1) - lc(base), 32'd10);
        check("timeout flag",    {31'd0, o_ack_timeout}, 32'd1);
        check("timeout no done", done_cnt - d0, 32'd0);
        tx_silent = 1'b0;

        // Reset while byte 0 is in flight with two words queued
        push(16'h0A0B);
        push(16'h0C0D);
        push(16'h0E0F);
        tick(3);
        check("pre-reset count",   {29'd0, o_count},   32'd2);
        check("pre-reset sending", {31'd0, o_sending}, 32'd1);
        reset = 1'b1;
        tick(1);
        check("midreset outputs", {o_tx_start, o_tx_data, o_full, o_sending, o_word_done,
                                   o_overflow, o_ack_timeout}, 32'd0);
        check("midreset count", {29'd0, o_count}, 32'd0);
        reset = 1'b0;
        base = log_b.size();
        tick(30);
        check("post-reset no starts", log_b.size() - base, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
